mips_muldiv: RTL
================

// Module: mips_muldiv
// PURPOSE
//  Iterative multiply/divide unit for the MIPS core, directly downstream of the
//  register file read ports: consumes RF operands A/B for MULT/MULTU/DIV/DIVU.
//  Holds the architectural HI/LO registers and supports MTHI/MTLO writes.
//  While an operation runs, busy stalls the pipeline. MFHI/MFLO read hi/lo directly.
// PARAMETERS
//  WIDTH    32  operand width; results are 2*WIDTH split across hi/lo.
//  LATENCY  derived, WIDTH+1; clocks from the start edge to the result edge.
// PORTS
//  clk      in   1      rising-edge clock
//  reset_n  in   1      asynchronous, active-low reset
//  start    in   1      launch op; sampled only when busy=0
//  op       in   2      0=MULT 1=MULTU 2=DIV 3=DIVU
//  a        in   WIDTH  rs operand (RF port A); dividend/multiplicand
//  b        in   WIDTH  rt operand (RF port B); divisor/multiplier
//  cancel   in   1      pipeline flush; abort in-flight op
//  mthi     in   1      write wd to hi (idle only)
//  mtlo     in   1      write wd to lo (idle only)
//  wd       in   WIDTH  MTHI/MTLO data
//  busy     out  1      op in flight; high from the start edge to the result edge
//  done     out  1      one-cycle pulse; high in the cycle after hi/lo are updated
//  hi       out  WIDTH  HI register (product[63:32] / remainder)
//  lo       out  WIDTH  LO register (product[31:0] / quotient)
// BEHAVIOUR
//  Reset (async, reset_n=0): state=IDLE, busy=0, done=0, hi=0, lo=0, count=0.
//  FSM IDLE -> ITER -> FIX -> IDLE.
//  - IDLE: if start, capture |a|,|b| (magnitudes for signed ops; raw for unsigned),
//    the result signs, and op; count=0; go to ITER.
//    start has priority over mthi/mtlo in the same cycle; the writes are dropped.
//  - ITER: one radix-2 step per clock, WIDTH clocks (count 0..WIDTH-1).
//    MUL: shift-add on a 2*WIDTH accumulator.
//    DIV: restoring shift-subtract, producing quotient and remainder magnitudes.
//  - FIX: apply signs, then write hi/lo at this edge.
//    MULT: negate the 64-bit product if sign(a)^sign(b).
//    DIV:  quotient takes sign(a)^sign(b); remainder takes sign(a).
//    After this edge: busy=0, done=1 for exactly one cycle; next state IDLE.
//  Timing: start sampled at edge E0 -> busy=1 after E0 -> hi/lo valid and
//    busy=0 after edge E0+WIDTH+1 (E33 for WIDTH=32).
//    A back-to-back start is legal in the cycle where done=1.
//  Signed arithmetic is two's complement; the signed overflow case wraps:
//    0x80000000 / -1 gives lo=0x80000000, hi=0.
//  Divide by zero is defined, not trapped; the latency is unchanged:
//    DIVU: lo=0xFFFFFFFF, hi=a.
//    DIV:  lo=0xFFFFFFFF if a>=0, else 0x00000001; hi=a.
//  start while busy=1: ignored; no queueing.
//  mthi/mtlo while busy=1: ignored.
//  mthi/mtlo while idle: write at the next edge; both may assert together.
//  cancel while busy: return to IDLE at the next edge.
//    hi/lo keep their pre-op values; done is not pulsed; busy=0 after that edge.
//    cancel has priority over the FIX write in the same cycle.
//    cancel while idle has no effect, and the same-cycle start is also dropped.
//  reset_n low mid-operation: immediately IDLE with hi=lo=0; no done pulse.
// TESTING
//  1 MULTU a=FFFFFFFF b=FFFFFFFF -> busy=1 for 33 clocks; hi=FFFFFFFE, lo=00000001; done pulse x1.
//  2 MULT a=-3 b=7 -> hi=FFFFFFFF lo=FFFFFFEB.
//    MULT a=b=80000000 -> hi=40000000 lo=0.
//  3 DIV a=-7 b=2 -> lo=FFFFFFFD hi=FFFFFFFF.
//    DIV a=80000000 b=FFFFFFFF -> lo=80000000 hi=0.
//    DIVU a=7 b=0 -> lo=FFFFFFFF hi=7.
//  4 start with a new op at busy clock 5 -> first result unchanged; no second done.
//    start asserted on the done cycle -> second op completes 33 clocks later.
//  5 mthi wd=1234 idle -> hi=1234 next clk.
//    mtlo while busy -> lo unaffected; mthi+start same cycle -> write dropped.
//  6 cancel at busy clock 20 -> busy=0 next clk; hi/lo unchanged; no done.
//    reset_n pulse mid-op -> hi=lo=0, busy=0 asynchronously.

Source files
------------

// File: rtl/mips_muldiv_if.sv
`default_nettype none
// ============================================================================
//  Module      : mips_muldiv_if
//  Description : Operand, control and result bundle between the MIPS pipeline
//                and the iterative multiply/divide unit.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mips_muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cancel;
    logic             mthi;
    logic             mtlo;
    logic [WIDTH-1:0] wd;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    // Pipeline side: issues operations and reads HI/LO
    modport master (
        output start, op, a, b, cancel, mthi, mtlo, wd,
        input  busy, done, hi, lo
    );

    // Unit side
    modport slave (
        input  start, op, a, b, cancel, mthi, mtlo, wd,
        output busy, done, hi, lo
    );
endinterface
`default_nettype wire

// File: rtl/mips_muldiv.sv
`default_nettype none
// ============================================================================
//  Module      : mips_muldiv
//  Description : Iterative radix-2 multiply/divide unit holding the HI/LO
//                registers. MULT/MULTU/DIV/DIVU complete WIDTH+1 clocks after
//                the start edge; MTHI/MTLO write HI/LO while idle.
//  Revision    : 1.0 - initial release
// ============================================================================
module mips_muldiv #(
    parameter int WIDTH = 32
) (
    input  wire logic     clk,
    input  wire logic     reset_n,
    mips_muldiv_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      count_q, count_d;
    // MUL: {partial product, remaining multiplier}; DIV: {remainder, quotient/dividend}
    logic [2*WIDTH-1:0] acc_q, acc_d;
    // Multiplicand magnitude (MUL) or divisor magnitude (DIV)
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic               is_div_q, is_div_d;
    logic               neg_q, neg_d;        // negate product / quotient
    logic               rem_neg_q, rem_neg_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;

    logic               w_signed_op;
    logic               w_a_neg, w_b_neg;
    logic [WIDTH-1:0]   w_a_mag, w_b_mag;
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_next;
    logic [WIDTH:0]     w_trial;
    logic [2*WIDTH-1:0] w_div_next;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quot, w_rem;

    // Operand magnitudes, one iteration step for each operation, and sign fix-up
    always_comb begin
        w_signed_op = ~bus.op[0];
        w_a_neg     = w_signed_op & bus.a[WIDTH-1];
        w_b_neg     = w_signed_op & bus.b[WIDTH-1];
        w_a_mag     = w_a_neg ? (~bus.a + 1'b1) : bus.a;
        w_b_mag     = w_b_neg ? (~bus.b + 1'b1) : bus.b;

        // Shift-add: add multiplicand if multiplier LSB set, then shift right with carry
        w_mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
        w_mul_next  = {w_mul_sum, acc_q[WIDTH-1:1]};

        // Restoring divide: trial-subtract divisor from the shifted remainder;
        // the borrow bit tells whether the subtraction is kept.
        w_trial     = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, opb_q};
        w_div_next  = w_trial[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                                     : {w_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

        w_prod      = neg_q     ? (~acc_q + 1'b1) : acc_q;
        w_quot      = neg_q     ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
        w_rem       = rem_neg_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1) : acc_q[2*WIDTH-1:WIDTH];
    end

    // Next-state and datapath update
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        acc_d     = acc_q;
        opb_d     = opb_q;
        is_div_d  = is_div_q;
        neg_d     = neg_q;
        rem_neg_d = rem_neg_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start && !bus.cancel) begin
                    // A launch wins over same-cycle MTHI/MTLO, which are dropped
                    is_div_d  = bus.op[1];
                    neg_d     = w_a_neg ^ w_b_neg;
                    rem_neg_d = w_a_neg;
                    acc_d     = bus.op[1] ? {{WIDTH{1'b0}}, w_a_mag} : {{WIDTH{1'b0}}, w_b_mag};
                    opb_d     = bus.op[1] ? w_b_mag : w_a_mag;
                    count_d   = '0;
                    state_d   = S_ITER;
                end else begin
                    if (bus.mthi) hi_d = bus.wd;
                    if (bus.mtlo) lo_d = bus.wd;
                end
            end
            S_ITER: begin
                if (bus.cancel) begin
                    state_d = S_IDLE;
                end else begin
                    acc_d   = is_div_q ? w_div_next : w_mul_next;
                    count_d = count_q + 1'b1;
                    if (count_q == CW'(WIDTH-1)) state_d = S_FIX;
                end
            end
            S_FIX: begin
                // A flush here still discards the result
                if (!bus.cancel) begin
                    if (is_div_q) begin
                        hi_d = w_rem;
                        lo_d = w_quot;
                    end else begin
                        hi_d = w_prod[2*WIDTH-1:WIDTH];
                        lo_d = w_prod[WIDTH-1:0];
                    end
                    done_d = 1'b1;
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            acc_q     <= '0;
            opb_q     <= '0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            acc_q     <= acc_d;
            opb_q     <= opb_d;
            is_div_q  <= is_div_d;
            neg_q     <= neg_d;
            rem_neg_q <= rem_neg_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
        end
    end

    assign bus.busy = (state_q != S_IDLE);
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule
`default_nettype wire
